// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multi-cycle MIPS control FSM with memory handshake, timeout trap, illegal-op trap and retire counter
module uc_multiciclo #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         OP,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic               bus_err,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   instr_count
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    RTYPE_EX = 4'd6, ALU_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, IMM_EX = 4'd10, TRAP = 4'd11
  } stateT;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010;
  localparam int WAIT_W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  stateT curState, nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic memWait, timeout, retire;
  assign state = curState;
  always_comb begin
    memWait = curState inside {FETCH, MEMREAD, MEMWRITE} && !mem_ready;
    // the cycle that would be the MEM_TIMEOUT-th held cycle traps instead of holding
    timeout = memWait && waitCnt == WAIT_W'(MEM_TIMEOUT - 1);
    nextState = FETCH;
    case (curState)
      FETCH:    nextState = mem_ready ? DECODE : FETCH;
      DECODE:   nextState = OP == OP_R ? RTYPE_EX :
                            OP inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI} ? IMM_EX :
                            OP inside {OP_LW, OP_SW} ? MEMADDR :
                            OP == OP_BEQ ? BRANCH :
                            OP == OP_J ? JUMP : TRAP;
      MEMADDR:  nextState = OP == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  nextState = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: nextState = mem_ready ? FETCH : MEMWRITE;
      RTYPE_EX: nextState = ALU_WB;
      IMM_EX:   nextState = ALU_WB;
      TRAP:     nextState = TRAP;
      default:  nextState = FETCH;
    endcase
    if (timeout) nextState = TRAP;
    retire = rst_n && nextState == FETCH && curState inside {MEMWB, MEMWRITE, ALU_WB, BRANCH, JUMP};
  end
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegDst = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUOP = '0;
    PCSource = 2'b00;
    if (rst_n) begin
      case (curState)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          IorD = 1'b1;
        end
        MEMWB: begin
          MemToReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEMWRITE: begin
          MemWrite = 1'b1;
          IorD = 1'b1;
        end
        RTYPE_EX: begin
          ALUSrcA = 1'b1;
          ALUOP = ALUOP_W'(3'b100);
        end
        ALU_WB: begin
          RegWrite = 1'b1;
          RegDst = OP == OP_R;
        end
        IMM_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOP = OP == OP_SLTI ? ALUOP_W'(3'b001) :
                  OP == OP_ANDI ? ALUOP_W'(3'b010) :
                  OP == OP_ORI  ? ALUOP_W'(3'b011) : ALUOP_W'(3'b000);
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOP = ALUOP_W'(3'b101);
          PCWriteCond = 1'b1;
          PCSource = 2'b01;
        end
        JUMP: begin
          PCWrite = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      curState <= FETCH;
      waitCnt <= '0;
      instr_count <= '0;
      illegal_op <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      curState <= nextState;
      waitCnt <= memWait && nextState == curState ? waitCnt + 1'b1 : '0;
      instr_count <= instr_count + CNT_W'(retire);
      illegal_op <= illegal_op | (curState == DECODE && nextState == TRAP);
      bus_err <= bus_err | timeout;
    end
  end
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: directed scoreboard bench for the multi-cycle control unit (MEM_TIMEOUT=4)
module tb_uc_multiciclo;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = 6'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOP;
  logic illegal_op, bus_err;
  logic [3:0] state;
  logic [31:0] instr_count;
  logic [16:0] ctl;
  int checks = 0, errors = 0;
  typedef struct {string tag; logic [31:0] val;} expT;
  expT sb[$];
  localparam logic [16:0] C_FR  = 17'b1_0_0_1_0_1_0_0_0_0_01_000_00, C_FW  = 17'b0_0_0_1_0_0_0_0_0_0_01_000_00,
                          C_DEC = 17'b0_0_0_0_0_0_0_0_0_0_11_000_00, C_MA  = 17'b0_0_0_0_0_0_0_0_0_1_10_000_00,
                          C_MR  = 17'b0_0_1_1_0_0_0_0_0_0_00_000_00, C_MWB = 17'b0_0_0_0_0_0_0_1_1_0_00_000_00,
                          C_MW  = 17'b0_0_1_0_1_0_0_0_0_0_00_000_00, C_RX  = 17'b0_0_0_0_0_0_0_0_0_1_00_100_00,
                          C_WBR = 17'b0_0_0_0_0_0_1_0_1_0_00_000_00, C_WBI = 17'b0_0_0_0_0_0_0_0_1_0_00_000_00,
                          C_ORI = 17'b0_0_0_0_0_0_0_0_0_1_10_011_00, C_BR  = 17'b0_1_0_0_0_0_0_0_0_1_00_101_01,
                          C_J   = 17'b1_0_0_0_0_0_0_0_0_0_00_000_10, C_0   = 17'b0;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ORI = 6'b001101,
                         BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUOP, PCSource};
  uc_multiciclo #(.ALUOP_W(3), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .OP(op), .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP),
    .PCSource(PCSource), .illegal_op(illegal_op), .bus_err(bus_err), .state(state), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic pop(input logic [31:0] obs);
    expT e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] v);
    push(tag, v);
    pop(obs);
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic step(input logic rdy, input logic [3:0] es, input logic [16:0] ec);
    mem_ready = rdy;
    push("state", {28'b0, es});
    push("ctl", {15'b0, ec});
    #1;
    pop({28'b0, state});
    pop({15'b0, ctl});
    tick();
  endtask
  initial begin
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_state", {28'b0, state}, 32'd0);
    check("rst_ctl_forced0", {15'b0, ctl}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_flags", {30'b0, illegal_op, bus_err}, 32'd0);
    rst_n = 1'b1;
    op = LW;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 2, C_MA); step(1, 3, C_MR);
    check("lw_count_before", instr_count, 32'd0);
    step(1, 4, C_MWB);
    check("lw_count", instr_count, 32'd1);
    op = RT;
    step(0, 0, C_FW); step(0, 0, C_FW); step(0, 0, C_FW); step(1, 0, C_FR);
    step(1, 1, C_DEC); step(1, 6, C_RX); step(1, 7, C_WBR);
    check("r_count", instr_count, 32'd2);
    op = ORI;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 10, C_ORI); step(1, 7, C_WBI);
    check("ori_count", instr_count, 32'd3);
    op = BEQ;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 8, C_BR);
    check("beq_count", instr_count, 32'd4);
    op = JMP;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 9, C_J);
    check("j_count", instr_count, 32'd5);
    op = LW;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 2, C_MA);
    step(0, 3, C_MR); step(0, 3, C_MR); step(0, 3, C_MR); step(1, 3, C_MR);
    step(1, 4, C_MWB);
    check("lw_ready_on_timeout_wins", {31'b0, bus_err}, 32'd0);
    check("lw_wait_count", instr_count, 32'd6);
    op = SW;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 2, C_MA);
    step(0, 5, C_MW); step(0, 5, C_MW); step(0, 5, C_MW); step(0, 5, C_MW);
    step(0, 11, C_0);
    check("timeout_bus_err", {31'b0, bus_err}, 32'd1);
    step(1, 11, C_0);
    check("bus_err_sticky", {31'b0, bus_err}, 32'd1);
    check("trap_count", instr_count, 32'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_flags", {30'b0, illegal_op, bus_err}, 32'd0);
    check("rst2_count", instr_count, 32'd0);
    op = BAD;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 11, C_0);
    check("illegal_flag", {31'b0, illegal_op}, 32'd1);
    check("illegal_count", instr_count, 32'd0);
    step(1, 11, C_0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    op = SW;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 2, C_MA); step(1, 5, C_MW);
    check("sw_count", instr_count, 32'd1);
    op = LW;
    step(1, 0, C_FR); step(1, 1, C_DEC); step(1, 2, C_MA);
    mem_ready = 1'b0;
    #1;
    check("pre_abort_ctl", {15'b0, ctl}, {15'b0, C_MR});
    rst_n = 1'b0;
    #1;
    check("abort_ctl_same_cycle", {15'b0, ctl}, 32'd0);
    tick();
    check("abort_state", {28'b0, state}, 32'd0);
    check("abort_count", instr_count, 32'd0);
    check("abort_flags", {30'b0, illegal_op, bus_err}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
